// File: rtl/fifo_sync_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_pkg
// Shared helpers for the programmable synchronous FIFO:
//   clog2        - ceiling log2 for sizing derived from a depth
//   count_width  - width of pointers/occupancy for a given address width
//   fifo_status_t - bundle of the FIFO status flags
// -----------------------------------------------------------------------------
package fifo_sync_pkg;

   // Ceiling log2; the loop bound keeps the function elaboration-safe.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << result) < value) begin
            result = result + 1;
         end
      end
      return result;
   endfunction

   // Pointers and occupancy carry one extra bit so that full and empty differ.
   function automatic int count_width(input int address_width);
      return address_width + 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/fifo_sync_ram.sv
// -----------------------------------------------------------------------------
// fifo_sync_ram
// Simple dual-port RAM, DATA_WIDTH x 2**ADDRESS_WIDTH, one write port and one
// registered read port. Storage is not reset; only the read register is.
// Ports:
//   clk, reset          - clock, synchronous active-high reset (read register)
//   wr_en/wr_addr/wr_data - write port
//   rd_en/rd_addr       - read request; rd_data updates on the edge, else holds
//   rd_data             - registered read data
// -----------------------------------------------------------------------------
module fifo_sync_ram #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     rd_en,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [0:(1 << ADDRESS_WIDTH)-1];

   // storage write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // registered read port, holds its value when no read is requested
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// fifo_sync_prog
// Synchronous FIFO with protected push/pop, exact occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// Optional macro FIFO_SYNC_FWFT_EN selects first-word-fall-through reads;
// without it reads have one cycle of latency.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   wr_en, data_in, wr_rdy    - push side (wr_rdy = ~full)
//   rd_en, data_out, rd_rdy   - pop side (rd_rdy = ~empty)
//   afull_thresh, aempty_thresh - almost_full / almost_empty levels
//   count                     - occupancy 0..FIFO_DEPTH
//   full, empty, almost_full, almost_empty - status
//   overflow, underflow, err_clr - sticky errors and their clear
// -----------------------------------------------------------------------------
module fifo_sync_prog
   import fifo_sync_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  data_in,
   output logic                   wr_rdy,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   rd_rdy,
   input  logic [ADDRESS_WIDTH:0] afull_thresh,
   input  logic [ADDRESS_WIDTH:0] aempty_thresh,
   output logic [ADDRESS_WIDTH:0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   err_clr
);

   localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
   localparam int CW         = count_width(ADDRESS_WIDTH);
   localparam logic [ADDRESS_WIDTH:0] DEPTH_COUNT = CW'(FIFO_DEPTH);
   localparam logic [ADDRESS_WIDTH:0] PTR_ZERO    = {(ADDRESS_WIDTH+1){1'b0}};
   localparam logic [ADDRESS_WIDTH:0] PTR_ONE     = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

   logic [ADDRESS_WIDTH:0] wr_ad_r;
   logic [ADDRESS_WIDTH:0] rd_ad_r;
   logic [ADDRESS_WIDTH:0] ram_count_s;
   logic [ADDRESS_WIDTH:0] count_s;
   logic                   full_s;
   logic                   empty_s;
   logic                   wr_acc_s;
   logic                   rd_acc_s;
   logic                   ram_we_s;
   logic                   ram_rd_en_s;
   logic                   overflow_r;
   logic                   underflow_r;
   fifo_status_t           status_s;
`ifdef FIFO_SYNC_FWFT_EN
   logic                   fwft_valid_r;
`endif

   // occupancy, full/empty and accept decode from pre-edge state
   always_comb begin
      ram_count_s = wr_ad_r - rd_ad_r;
`ifdef FIFO_SYNC_FWFT_EN
      // the head word sitting in the output register is part of the occupancy
      count_s     = ram_count_s + {{ADDRESS_WIDTH{1'b0}}, fwft_valid_r};
      empty_s     = ~fwft_valid_r;
`else
      count_s     = ram_count_s;
      empty_s     = (count_s == PTR_ZERO);
`endif
      full_s      = (count_s == DEPTH_COUNT);
      wr_acc_s    = wr_en & ~full_s;
      rd_acc_s    = rd_en & ~empty_s;
      ram_we_s    = wr_acc_s & ~reset;
`ifdef FIFO_SYNC_FWFT_EN
      // refill the output register when it is empty or being popped
      ram_rd_en_s = (ram_count_s != PTR_ZERO) & (~fwft_valid_r | rd_acc_s);
`else
      ram_rd_en_s = rd_acc_s;
`endif
   end

   // write/read pointers; the extra top bit distinguishes full from empty
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ad_r <= PTR_ZERO;
         rd_ad_r <= PTR_ZERO;
      end else begin
         if (wr_acc_s) begin
            wr_ad_r <= wr_ad_r + PTR_ONE;
         end
         if (ram_rd_en_s) begin
            rd_ad_r <= rd_ad_r + PTR_ONE;
         end
      end
   end

`ifdef FIFO_SYNC_FWFT_EN
   // output register valid: set on every refill, cleared when the last head is popped
   always_ff @(posedge clk) begin
      if (reset) begin
         fwft_valid_r <= 1'b0;
      end else if (ram_rd_en_s) begin
         fwft_valid_r <= 1'b1;
      end else if (rd_acc_s) begin
         fwft_valid_r <= 1'b0;
      end else begin
         fwft_valid_r <= fwft_valid_r;
      end
   end
`endif

   // sticky error flags; a new error in the same cycle beats err_clr
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_en & full_s) begin
            overflow_r <= 1'b1;
         end else if (err_clr) begin
            overflow_r <= 1'b0;
         end
         if (rd_en & empty_s) begin
            underflow_r <= 1'b1;
         end else if (err_clr) begin
            underflow_r <= 1'b0;
         end
      end
   end

   // status bundle; thresholds are live inputs so changes show immediately
   always_comb begin
      status_s.full         = full_s;
      status_s.empty        = empty_s;
      status_s.almost_full  = (count_s >= afull_thresh);
      status_s.almost_empty = (count_s <= aempty_thresh);
      status_s.overflow     = overflow_r;
      status_s.underflow    = underflow_r;
   end

   assign full         = status_s.full;
   assign empty        = status_s.empty;
   assign almost_full  = status_s.almost_full;
   assign almost_empty = status_s.almost_empty;
   assign overflow     = status_s.overflow;
   assign underflow    = status_s.underflow;
   assign wr_rdy       = ~status_s.full;
   assign rd_rdy       = ~status_s.empty;
   assign count        = count_s;

   // storage; in first-word-fall-through mode its read register is the head slot
   fifo_sync_ram #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (ram_we_s),
      .wr_addr (wr_ad_r[ADDRESS_WIDTH-1:0]),
      .wr_data (data_in),
      .rd_en   (ram_rd_en_s),
      .rd_addr (rd_ad_r[ADDRESS_WIDTH-1:0]),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_prog
// Self-checking bench for fifo_sync_prog at depth 4, 8-bit data.
// Builds with or without FIFO_SYNC_FWFT_EN; the queue-based reference model
// follows whichever read mode is selected.
// -----------------------------------------------------------------------------
module tb_fifo_sync_prog;

   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          wr_rdy;
   logic          rd_en;
   logic [DW-1:0] data_out;
   logic          rd_rdy;
   logic [AW:0]   afull_thresh;
   logic [AW:0]   aempty_thresh;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic          underflow;
   logic          err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_sync_prog #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .data_in       (data_in),
      .wr_rdy        (wr_rdy),
      .rd_en         (rd_en),
      .data_out      (data_out),
      .rd_rdy        (rd_rdy),
      .afull_thresh  (afull_thresh),
      .aempty_thresh (aempty_thresh),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .overflow      (overflow),
      .underflow     (underflow),
      .err_clr       (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = 8'h00;
   bit            m_ovf  = 1'b0;
   bit            m_unf  = 1'b0;
`ifdef FIFO_SYNC_FWFT_EN
   bit            m_valid = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit w, input bit [DW-1:0] d, input bit r,
                             input bit c, input bit rs);
      int sz;
      bit mf, me, wa, ra;
      sz = q.size();
      mf = (sz == DEPTH);
`ifdef FIFO_SYNC_FWFT_EN
      me = !m_valid;
`else
      me = (sz == 0);
`endif
      wa = w && !mf;
      ra = r && !me;
      if (rs) begin
         q.delete();
         m_dout = 8'h00;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
`ifdef FIFO_SYNC_FWFT_EN
         m_valid = 1'b0;
`endif
      end else begin
         if (w && mf) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
         if (r && me) m_unf = 1'b1;
         else if (c) m_unf = 1'b0;
         if (ra) m_dout = q.pop_front();
`ifdef FIFO_SYNC_FWFT_EN
         // head becomes visible one edge after it entered an empty FIFO
         if (ra) m_valid = (q.size() > 0);
         else if (!m_valid) m_valid = (sz > 0);
         if (m_valid) m_dout = q[0];
`endif
         if (wa) q.push_back(d);
      end
   endtask

   task automatic model_check();
      int sz;
      bit mf, me;
      sz = q.size();
      mf = (sz == DEPTH);
`ifdef FIFO_SYNC_FWFT_EN
      me = !m_valid;
`else
      me = (sz == 0);
`endif
      chk("m_count", 32'(count), 32'(sz));
      chk("m_full", 32'(full), 32'(mf));
      chk("m_empty", 32'(empty), 32'(me));
      chk("m_wr_rdy", 32'(wr_rdy), 32'(!mf));
      chk("m_rd_rdy", 32'(rd_rdy), 32'(!me));
      chk("m_almost_full", 32'(almost_full), 32'(sz >= int'(afull_thresh)));
      chk("m_almost_empty", 32'(almost_empty), 32'(sz <= int'(aempty_thresh)));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_SYNC_FWFT_EN
      if (m_valid) chk("m_data_out", 32'(data_out), 32'(m_dout));
`else
      chk("m_data_out", 32'(data_out), 32'(m_dout));
`endif
   endtask

   // one clock: drive, edge, advance model, compare 1 time unit later
   task automatic step(input bit w, input bit [DW-1:0] d, input bit r,
                       input bit c, input bit rs);
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      err_clr = c;
      reset   = rs;
      @(posedge clk);
      model_edge(w, d, r, c, rs);
      #1;
      model_check();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          w;
      bit [DW-1:0] d;
      bit          r;
      bit          c;
      bit          rs;
      int          e_count;
      bit          e_full;
      bit          e_empty;
      bit          e_af;
      bit          e_ae;
      bit          e_ovf;
      bit          e_unf;
      bit [DW-1:0] e_dout;
   } vec_t;

   vec_t vt[$];

   task automatic add(input bit w, input bit [DW-1:0] d, input bit r, input bit c,
                      input bit rs, input int cnt, input bit f, input bit e,
                      input bit af, input bit ae, input bit ov, input bit un,
                      input bit [DW-1:0] dout);
      vec_t v;
      v.w = w; v.d = d; v.r = r; v.c = c; v.rs = rs;
      v.e_count = cnt; v.e_full = f; v.e_empty = e; v.e_af = af; v.e_ae = ae;
      v.e_ovf = ov; v.e_unf = un; v.e_dout = dout;
      vt.push_back(v);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      data_in = 8'h00; afull_thresh = 3'd3; aempty_thresh = 3'd1;

`ifndef FIFO_SYNC_FWFT_EN
      //   w  d      r  c  rs  cnt f  e  af ae ov un dout
      add(0, 8'h00, 0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 8'h00); // reset
      add(1, 8'hA0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 8'h00);
      add(1, 8'hA1, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h00);
      add(1, 8'hA2, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0, 8'h00);
      add(1, 8'hA3, 0, 0, 0,  4, 1, 0, 1, 0, 0, 0, 8'h00);
      add(1, 8'hFF, 0, 0, 0,  4, 1, 0, 1, 0, 1, 0, 8'h00); // overflow
      add(0, 8'h00, 1, 0, 0,  3, 0, 0, 1, 0, 1, 0, 8'hA0);
      add(0, 8'h00, 1, 0, 0,  2, 0, 0, 0, 0, 1, 0, 8'hA1);
      add(0, 8'h00, 1, 0, 0,  1, 0, 0, 0, 1, 1, 0, 8'hA2);
      add(0, 8'h00, 1, 0, 0,  0, 0, 1, 0, 1, 1, 0, 8'hA3);
      add(0, 8'h00, 1, 0, 0,  0, 0, 1, 0, 1, 1, 1, 8'hA3); // underflow, dout held
      add(0, 8'h00, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 8'hA3); // err_clr
      add(1, 8'h10, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 8'hA3);
      add(1, 8'h11, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'hA3);
      add(1, 8'h12, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h10); // simultaneous, wraps
      add(1, 8'h13, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h11);
      add(1, 8'h14, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h12);
      add(1, 8'h15, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h13);
      add(1, 8'h16, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h14);
      add(1, 8'h17, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h15);
      add(1, 8'h18, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0, 8'h15);
      add(1, 8'h19, 0, 0, 0,  4, 1, 0, 1, 0, 0, 0, 8'h15);
      add(1, 8'hEE, 1, 0, 0,  3, 0, 0, 1, 0, 1, 0, 8'h16); // full + both
      add(0, 8'h00, 0, 1, 0,  3, 0, 0, 1, 0, 0, 0, 8'h16);
      add(0, 8'h00, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 8'h17);
      add(0, 8'h00, 1, 0, 0,  1, 0, 0, 0, 1, 0, 0, 8'h18);
      add(0, 8'h00, 1, 0, 0,  0, 0, 1, 0, 1, 0, 0, 8'h19); // EE was rejected

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].w, vt[i].d, vt[i].r, vt[i].c, vt[i].rs);
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_count));
         chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].e_full));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
         chk($sformatf("vec%0d_almost_full", i), 32'(almost_full), 32'(vt[i].e_af));
         chk($sformatf("vec%0d_almost_empty", i), 32'(almost_empty), 32'(vt[i].e_ae));
         chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
         chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vt[i].e_unf));
         chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vt[i].e_dout));
      end
`else
      // first-word-fall-through: head appears one edge after the write
      step(0, 8'h00, 0, 0, 1);
      chk("fwft_reset_rd_rdy", 32'(rd_rdy), 32'd0);
      step(1, 8'h55, 0, 0, 0);
      chk("fwft_w55_count", 32'(count), 32'd1);
      chk("fwft_w55_rd_rdy_early", 32'(rd_rdy), 32'd0);
      step(0, 8'h00, 0, 0, 0);
      chk("fwft_w55_rd_rdy", 32'(rd_rdy), 32'd1);
      chk("fwft_w55_data", 32'(data_out), 32'h55);
      step(1, 8'h66, 0, 0, 0);
      chk("fwft_w66_head", 32'(data_out), 32'h55);
      chk("fwft_w66_count", 32'(count), 32'd2);
      step(0, 8'h00, 1, 0, 0);
      chk("fwft_pop_data", 32'(data_out), 32'h66);
      chk("fwft_pop_rd_rdy", 32'(rd_rdy), 32'd1);
      chk("fwft_pop_count", 32'(count), 32'd1);
      step(1, 8'h77, 0, 0, 0);
      step(1, 8'h88, 1, 0, 0);
      step(1, 8'h99, 0, 0, 1);
      chk("fwft_rst_rd_rdy", 32'(rd_rdy), 32'd0);
      chk("fwft_rst_count", 32'(count), 32'd0);
`endif

      // threshold sequence: thresholds act combinationally on the count
      afull_thresh = 3'd3; aempty_thresh = 3'd1;
      step(0, 8'h00, 0, 0, 1);
      chk("thr_c0_ae", 32'(almost_empty), 32'd1);
      chk("thr_c0_af", 32'(almost_full), 32'd0);
      step(1, 8'h31, 0, 0, 0);
      chk("thr_c1_ae", 32'(almost_empty), 32'd1);
      step(1, 8'h32, 0, 0, 0);
      chk("thr_c2_ae", 32'(almost_empty), 32'd0);
      chk("thr_c2_af", 32'(almost_full), 32'd0);
      step(1, 8'h33, 0, 0, 0);
      chk("thr_c3_af", 32'(almost_full), 32'd1);
      afull_thresh = 3'd4;
      #1;
      chk("thr_c3_af_moved", 32'(almost_full), 32'd0);
      model_check();
      step(1, 8'h34, 0, 0, 0);
      chk("thr_c4_af", 32'(almost_full), 32'd1);
      chk("thr_c4_full", 32'(full), 32'd1);
      afull_thresh = 3'd3;
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
      chk("thr_drained_count", 32'(count), 32'd0);

      // randomized traffic with phases biased toward filling and draining
      for (int i = 0; i < 3000; i++) begin
         int pw, pr;
         bit w, r, c, rs;
         pw = ((i / 200) % 2 == 0) ? 70 : 30;
         pr = 100 - pw;
         if (i % 47 == 0) begin
            afull_thresh  = 3'($urandom_range(0, 7));
            aempty_thresh = 3'($urandom_range(0, 7));
         end
         w  = ($urandom_range(0, 99) < pw);
         r  = ($urandom_range(0, 99) < pr);
         c  = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 249) == 0);
         step(w, 8'($urandom), r, c, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
